spi_slave_responder: RTL and testbench

- SPI mode-0 slave (CPOL=0, CPHA=0, MSB first), clocked entirely by clk_50.
- Oversamples the SCK/CSN/MOSI lines driven by the SPI master.
  - In that master, SCK comes from spi_clock_divider (clk_10).
- Presents received bytes on a byte-level interface and returns host-supplied bytes on MISO.
- Serves as the nRF24L01-side responder: bench model for the master path and loopback target on the DE10-Lite.

---
 rtl/spi_slave_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) that runs entirely on clk_50_i.
// SCK, CSN and MOSI are oversampled through synchronizer chains. Received words
// are presented on a byte-level interface. Host-supplied words, held in a
// one-entry holding register, are shifted back out on MISO. If no word is
// buffered when one is needed, FILL is sent and tx_underrun_o pulses.
//
// Optional feature macro: SPI_SLAVE_BYTE_CNT_EN
//   When defined, adds frame_word_cnt_o, the number of words completed in the
//   current (or most recent) frame. The count saturates at 255.
//
// Ports:
//   clk_50_i          system clock; SCK must be <= clk_50/4
//   rst_i             synchronous active-high reset
//   sck_i             asynchronous SPI clock from the master
//   csn_n_i           asynchronous chip select, active low
//   mosi_i            asynchronous master-out data
//   miso_o            slave-out data
//   miso_oe_o         high while a frame is active
//   rx_data_o         last complete received word
//   rx_valid_o        one-cycle pulse when rx_data_o updates
//   tx_data_i         next word to send
//   tx_load_i         write tx_data_i into the holding register
//   tx_empty_o        holding register is free
//   tx_underrun_o     one-cycle pulse when FILL was loaded instead of data
//   frame_word_cnt_o  (SPI_SLAVE_BYTE_CNT_EN only) words completed in the frame
//
// FSM states:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | chip select inactive; MISO held low, waiting for csn fall
//   ST_ACTIVE | frame in progress; shifting bits on synced SCK edges
// -----------------------------------------------------------------------------
module spi_slave_responder #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] FILL        = 'h0E
) (
    input  logic             clk_50_i,
    input  logic             rst_i,
    input  logic             sck_i,
    input  logic             csn_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_load_i,
    output logic             tx_empty_o,
    output logic             tx_underrun_o
`ifdef SPI_SLAVE_BYTE_CNT_EN
    ,
    output logic [7:0]       frame_word_cnt_o
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers and edge strobes
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q, flush_q;
    logic sck_d1_q, csn_d1_q, mosi_d1_q;
    logic sck_rise_q, sck_fall_q, csn_fall_q, csn_rise_q;
    logic armed_q;
    logic sck_s, csn_s, mosi_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The synchronizers reset to idle levels, so the first real samples can
    // look like a csn fall. armed_q only rises once a genuine high csn has
    // propagated (flush_q tracks that), which also makes a reset mid-frame
    // ignore the remainder of that frame.
    always_ff @(posedge clk_50_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sck_d1_q    <= 1'b0;
            csn_d1_q    <= 1'b1;
            mosi_d1_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            csn_fall_q  <= 1'b0;
            csn_rise_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sck_d1_q    <= sck_s;
            csn_d1_q    <= csn_s;
            // mosi is delayed alongside the registered strobes so the bit
            // used on a rise is the one sampled together with SCK high.
            mosi_d1_q   <= mosi_s;
            sck_rise_q  <= sck_s & ~sck_d1_q;
            sck_fall_q  <= ~sck_s & sck_d1_q;
            csn_fall_q  <= ~csn_s & csn_d1_q;
            csn_rise_q  <= csn_s & ~csn_d1_q;
            armed_q     <= armed_q | (flush_q[SYNC_STAGES-1] & csn_s);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             word_done_q, word_done_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             tx_empty_q, tx_empty_d;
    logic             tx_underrun_q, tx_underrun_d;
    logic             miso_q, miso_d;
    logic             word_load;
    logic             frame_start;
    logic [WIDTH-1:0] rx_word;
`ifdef SPI_SLAVE_BYTE_CNT_EN
    logic [7:0]       word_cnt_q, word_cnt_d;
`endif

    always_ff @(posedge clk_50_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            word_done_q   <= 1'b0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            tx_empty_q    <= 1'b1;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
`ifdef SPI_SLAVE_BYTE_CNT_EN
            word_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_done_q   <= word_done_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            tx_empty_q    <= tx_empty_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
`ifdef SPI_SLAVE_BYTE_CNT_EN
            word_cnt_q    <= word_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_done_d   = word_done_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        tx_empty_d    = tx_empty_q;
        tx_underrun_d = 1'b0;
        miso_d        = miso_q;
        word_load     = 1'b0;
        frame_start   = 1'b0;
        rx_word       = {rx_shift_q[WIDTH-2:0], mosi_d1_q};

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (csn_fall_q && armed_q) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    word_load   = 1'b1;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // csn rise wins over any SCK edge seen in the same cycle.
                if (csn_rise_q) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    miso_d      = 1'b0;
                end else begin
                    if (sck_rise_q) begin
                        rx_shift_d = rx_word;
                        if (bit_cnt_q == CW'(WIDTH-1)) begin
                            rx_data_d   = rx_word;
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = '0;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    if (sck_fall_q) begin
                        if (word_done_q) begin
                            word_load   = 1'b1;
                            word_done_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                            miso_d     = tx_shift_q[WIDTH-2];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A tx_load coinciding with a load of an empty holding register
        // bypasses straight into the shifter.
        if (word_load) begin
            if (!tx_empty_q) begin
                tx_shift_d = hold_q;
                miso_d     = hold_q[WIDTH-1];
                if (tx_load_i) begin
                    hold_d = tx_data_i;
                end else begin
                    tx_empty_d = 1'b1;
                end
            end else if (tx_load_i) begin
                tx_shift_d = tx_data_i;
                miso_d     = tx_data_i[WIDTH-1];
            end else begin
                tx_shift_d    = FILL;
                miso_d        = FILL[WIDTH-1];
                tx_underrun_d = 1'b1;
            end
        end else if (tx_load_i) begin
            hold_d     = tx_data_i;
            tx_empty_d = 1'b0;
        end
    end

`ifdef SPI_SLAVE_BYTE_CNT_EN
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (frame_start) begin
            word_cnt_d = '0;
        end else if (rx_valid_d && (word_cnt_q != 8'hFF)) begin
            word_cnt_d = word_cnt_q + 8'd1;
        end
    end

    assign frame_word_cnt_o = word_cnt_q;
`endif

    assign miso_o        = miso_q;
    assign miso_oe_o     = (state_q == ST_ACTIVE);
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_empty_o    = tx_empty_q;
    assign tx_underrun_o = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// Bench for spi_slave_responder. A behavioural SPI master drives frames with
// SCK = clk_50/5 (high 2, low 3 cycles). The master ends a frame by dropping
// SCK and raising csn_n together, so the trailing edge does not cause a load.
// MISO is captured at the end of each high phase.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

    localparam int SS = 2;
    localparam int HI = 2;
    localparam int LO = 3;
    localparam logic [7:0] FILL_W = 8'h0E;

    typedef logic [7:0] word_arr_t [4];

    logic       clk = 1'b0;
    logic       rst;
    logic       sck, csn_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_empty, tx_underrun;
`ifdef SPI_SLAVE_BYTE_CNT_EN
    logic [7:0] frame_word_cnt;
`endif

    always #10 clk = ~clk;

    spi_slave_responder dut (
        .clk_50_i        (clk),
        .rst_i           (rst),
        .sck_i           (sck),
        .csn_n_i         (csn_n),
        .mosi_i          (mosi),
        .miso_o          (miso),
        .miso_oe_o       (miso_oe),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .tx_data_i       (tx_data),
        .tx_load_i       (tx_load),
        .tx_empty_o      (tx_empty),
        .tx_underrun_o   (tx_underrun)
`ifdef SPI_SLAVE_BYTE_CNT_EN
        ,
        .frame_word_cnt_o(frame_word_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Observed pulses
    logic [7:0] rx_q[$];
    int         valid_cnt   = 0;
    int         underrun_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            valid_cnt++;
        end
        if (tx_underrun === 1'b1) underrun_cnt++;
    end

    // Reference model: one-entry holding register feeding word loads.
    logic [7:0] m_hold;
    bit         m_hold_v  = 1'b0;
    int         m_under   = 0;

    function automatic logic [7:0] model_load();
        if (m_hold_v) begin
            m_hold_v = 1'b0;
            return m_hold;
        end
        m_under++;
        return FILL_W;
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        valid_cnt    = 0;
        underrun_cnt = 0;
        m_under      = 0;
    endtask

    task automatic preload(input logic [7:0] v);
        tx_data  = v;
        tx_load  = 1'b1;
        clk_wait(1);
        tx_load  = 1'b0;
        m_hold   = v;
        m_hold_v = 1'b1;
    endtask

    // Runs one frame. abort_bits>0 ends the frame after that many bits;
    // rst_bit>0 pulses reset in the low phase after that bit; sim_load
    // asserts tx_load in exactly the cycle the frame-start load happens.
    task automatic run_frame(input int nw, input word_arr_t w_in,
                             input int abort_bits, input int rst_bit,
                             input bit sim_load, input logic [7:0] sim_val,
                             output word_arr_t w_out);
        int nbits;
        nbits = (abort_bits > 0) ? abort_bits : nw * 8;
        for (int i = 0; i < 4; i++) w_out[i] = 8'h00;
        csn_n = 1'b0;
        mosi  = w_in[0][7];
        if (sim_load) begin
            clk_wait(SS + 1);
            tx_data = sim_val;
            tx_load = 1'b1;
            clk_wait(1);
            tx_load = 1'b0;
            clk_wait(6 - (SS + 2));
        end else begin
            clk_wait(6);
        end
        for (int b = 0; b < nbits; b++) begin
            sck = 1'b1;
            clk_wait(HI);
            if (b == 0) begin
                vectors++;
                if (miso_oe !== 1'b1) begin
                    miscompares++;
                    $display("FAIL frame_miso_oe got=%b exp=1", miso_oe);
                end
            end
            w_out[b / 8][7 - (b % 8)] = miso;
            sck = 1'b0;
            if (b == nbits - 1) begin
                csn_n = 1'b1;
                mosi  = 1'b0;
            end else begin
                mosi = w_in[(b + 1) / 8][7 - ((b + 1) % 8)];
            end
            if (b + 1 == rst_bit) begin
                rst = 1'b1;
                clk_wait(1);
                rst = 1'b0;
                m_hold_v = 1'b0;
                vectors++;
                if ({miso, miso_oe, rx_valid, tx_empty, tx_underrun, rx_data} !== {5'b00010, 8'h00}) begin
                    miscompares++;
                    $display("FAIL midrst_outputs got miso=%b oe=%b vld=%b empty=%b und=%b rx=%h exp 0 0 0 1 0 00",
                             miso, miso_oe, rx_valid, tx_empty, tx_underrun, rx_data);
                end
                clk_wait(LO - 1);
            end else begin
                clk_wait(LO);
            end
        end
        clk_wait(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; csn_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        clk_wait(3);
        vectors++;
        if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got=%b exp=0", miso); end
        vectors++;
        if (miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
        vectors++;
        if (tx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_tx_empty got=%b exp=1", tx_empty); end
        vectors++;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        vectors++;
        if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        vectors++;
        if (tx_underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
        rst = 1'b0;
        clk_wait(6);
        vectors++;
        if (miso_oe !== 1'b0) begin miscompares++; $display("FAIL idle_miso_oe got=%b exp=0", miso_oe); end
    endtask

    task automatic test_single();
        word_arr_t wi, wo;
        logic [7:0] exp0;
        clear_mon();
        preload(8'hA5);
        vectors++;
        if (tx_empty !== 1'b0) begin miscompares++; $display("FAIL single_empty_after_load got=%b exp=0", tx_empty); end
        wi = '{8'h3C, 8'h00, 8'h00, 8'h00};
        exp0 = model_load();
        run_frame(1, wi, 0, 0, 1'b0, 8'h00, wo);
        vectors++;
        if (wo[0] !== exp0) begin miscompares++; $display("FAIL single_miso got=%h exp=%h", wo[0], exp0); end
        vectors++;
        if (valid_cnt !== 1) begin miscompares++; $display("FAIL single_valid_cnt got=%0d exp=1", valid_cnt); end
        vectors++;
        if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL single_rx_data got=%h exp=3c", rx_data); end
        vectors++;
        if (tx_empty !== 1'b1) begin miscompares++; $display("FAIL single_empty got=%b exp=1", tx_empty); end
        vectors++;
        if (underrun_cnt !== m_under) begin miscompares++; $display("FAIL single_underrun got=%0d exp=%0d", underrun_cnt, m_under); end
    endtask

    task automatic test_underrun();
        word_arr_t wi, wo;
        logic [7:0] e0, e1;
        clear_mon();
        preload(8'h12);
        wi = '{8'hFF, 8'h01, 8'h00, 8'h00};
        e0 = model_load();
        e1 = model_load();
        run_frame(2, wi, 0, 0, 1'b0, 8'h00, wo);
        vectors++;
        if (wo[0] !== e0 || wo[1] !== e1) begin
            miscompares++;
            $display("FAIL underrun_miso got=%h,%h exp=%h,%h", wo[0], wo[1], e0, e1);
        end
        vectors++;
        if (underrun_cnt !== m_under) begin miscompares++; $display("FAIL underrun_count got=%0d exp=%0d", underrun_cnt, m_under); end
        vectors++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hFF || rx_q[1] !== 8'h01) begin
            miscompares++;
            $display("FAIL underrun_rx got n=%0d exp n=2 ff,01", rx_q.size());
        end
    endtask

    task automatic test_abort();
        word_arr_t wi, wo;
        logic [7:0] e0;
        clear_mon();
        wi = '{8'h55, 8'h00, 8'h00, 8'h00};
        void'(model_load());
        run_frame(1, wi, 5, 0, 1'b0, 8'h00, wo);
        vectors++;
        if (valid_cnt !== 0) begin miscompares++; $display("FAIL abort_valid got=%0d exp=0", valid_cnt); end
        clear_mon();
        wi = '{8'h81, 8'h00, 8'h00, 8'h00};
        e0 = model_load();
        run_frame(1, wi, 0, 0, 1'b0, 8'h00, wo);
        vectors++;
        if (rx_q.size() != 1 || rx_data !== 8'h81) begin
            miscompares++;
            $display("FAIL abort_next_rx got n=%0d data=%h exp n=1 81", rx_q.size(), rx_data);
        end
        vectors++;
        if (wo[0] !== e0) begin miscompares++; $display("FAIL abort_next_miso got=%h exp=%h", wo[0], e0); end
    endtask

    task automatic test_simul_load();
        word_arr_t wi, wo;
        clear_mon();
        wi = '{8'h66, 8'h00, 8'h00, 8'h00};
        run_frame(1, wi, 0, 0, 1'b1, 8'h5A, wo);
        vectors++;
        if (wo[0] !== 8'h5A) begin miscompares++; $display("FAIL simul_miso got=%h exp=5a", wo[0]); end
        vectors++;
        if (underrun_cnt !== 0) begin miscompares++; $display("FAIL simul_underrun got=%0d exp=0", underrun_cnt); end
        vectors++;
        if (tx_empty !== 1'b1) begin miscompares++; $display("FAIL simul_empty got=%b exp=1", tx_empty); end
        vectors++;
        if (rx_data !== 8'h66) begin miscompares++; $display("FAIL simul_rx got=%h exp=66", rx_data); end
    endtask

    task automatic test_reset_mid();
        word_arr_t wi, wo;
        logic [7:0] e0;
        clear_mon();
        wi = '{8'hE7, 8'h00, 8'h00, 8'h00};
        run_frame(1, wi, 0, 3, 1'b0, 8'h00, wo);
        vectors++;
        if (valid_cnt !== 0) begin miscompares++; $display("FAIL midrst_valid got=%0d exp=0", valid_cnt); end
        clear_mon();
        preload(8'h77);
        wi = '{8'hC3, 8'h00, 8'h00, 8'h00};
        e0 = model_load();
        run_frame(1, wi, 0, 0, 1'b0, 8'h00, wo);
        vectors++;
        if (rx_q.size() != 1 || rx_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL midrst_fresh_rx got n=%0d data=%h exp n=1 c3", rx_q.size(), rx_data);
        end
        vectors++;
        if (wo[0] !== e0) begin miscompares++; $display("FAIL midrst_fresh_miso got=%h exp=%h", wo[0], e0); end
    endtask

`ifdef SPI_SLAVE_BYTE_CNT_EN
    task automatic test_word_cnt();
        word_arr_t wi, wo;
        clear_mon();
        wi = '{8'h11, 8'h22, 8'h33, 8'h00};
        for (int k = 0; k < 3; k++) void'(model_load());
        run_frame(3, wi, 0, 0, 1'b0, 8'h00, wo);
        vectors++;
        if (frame_word_cnt !== 8'd3) begin miscompares++; $display("FAIL word_cnt got=%0d exp=3", frame_word_cnt); end
    endtask
`endif

    task automatic test_random();
        word_arr_t wi, wo, we;
        int nw;
        for (int it = 0; it < 20; it++) begin
            clear_mon();
            nw = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) wi[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) preload(8'($urandom));
            for (int k = 0; k < 4; k++) we[k] = (k < nw) ? model_load() : 8'h00;
            run_frame(nw, wi, 0, 0, 1'b0, 8'h00, wo);
            for (int k = 0; k < nw; k++) begin
                vectors++;
                if (wo[k] !== we[k]) begin
                    miscompares++;
                    $display("FAIL rand_miso it=%0d word=%0d got=%h exp=%h", it, k, wo[k], we[k]);
                end
                vectors++;
                if (rx_q.size() <= k || rx_q[k] !== wi[k]) begin
                    miscompares++;
                    $display("FAIL rand_rx it=%0d word=%0d got_n=%0d exp=%h", it, k, rx_q.size(), wi[k]);
                end
            end
            vectors++;
            if (valid_cnt !== nw) begin miscompares++; $display("FAIL rand_valid_cnt it=%0d got=%0d exp=%0d", it, valid_cnt, nw); end
            vectors++;
            if (underrun_cnt !== m_under) begin miscompares++; $display("FAIL rand_underrun it=%0d got=%0d exp=%0d", it, underrun_cnt, m_under); end
            vectors++;
            if (tx_empty !== 1'b1) begin miscompares++; $display("FAIL rand_empty it=%0d got=%b exp=1", it, tx_empty); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_underrun();
        test_abort();
        test_simul_load();
        test_reset_mid();
`ifdef SPI_SLAVE_BYTE_CNT_EN
        test_word_cnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
